// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
// Four-phase traffic intersection scheduler. Sequences ALLRED -> GREEN -> YELLOW
// intervals, granting phases round-robin from level detector requests with
// minimum/maximum green timing. All timing advances on the external `tick` pulse.
//
// Optional feature macro: EMERGENCY_PREEMPT_EN
//   defined   : emg_req/emg_phase steer the sequence toward emg_phase
//   undefined : emg_req/emg_phase ignored, preempt_active tied low
//
// Ports:
//   clk            - clock, rising edge
//   reset_n        - asynchronous active-low reset
//   tick           - one-cycle timebase pulse
//   req[3:0]       - level vehicle requests, one per phase
//   emg_req        - emergency preemption request (level)
//   emg_phase[1:0] - phase to serve on preemption
//   green/yellow/red[3:0] - registered lamp outputs per phase
//   active_phase[1:0]     - phase currently (or last) granted
//   phase_start    - one-cycle pulse on GREEN entry
//   preempt_active - high while preemption steers the sequence
module intersection_phase_scheduler #(
   parameter int unsigned MIN_GREEN = 5,
   parameter int unsigned MAX_GREEN = 20,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 2,
   parameter int unsigned CW        = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic [3:0] req,
   input  logic       emg_req,
   input  logic [1:0] emg_phase,
   output logic [3:0] green,
   output logic [3:0] yellow,
   output logic [3:0] red,
   output logic [1:0] active_phase,
   output logic       phase_start,
   output logic       preempt_active
);

   localparam logic [CW-1:0] MIN_LIM = CW'(MIN_GREEN - 1);
   localparam logic [CW-1:0] MAX_LIM = CW'(MAX_GREEN - 1);
   localparam logic [CW-1:0] YEL_LIM = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] AR_LIM  = CW'(ALLRED_T - 1);
   localparam logic [CW-1:0] TMR_ONE = CW'(1);

   typedef enum logic [1:0] {
      ST_ALLRED = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] tmr;
   logic [1:0]    last;

   logic       emg_on;
   logic [1:0] emg_ph;

`ifdef EMERGENCY_PREEMPT_EN
   assign emg_on = emg_req;
   assign emg_ph = emg_phase;
`else
   logic unused_emg;
   assign unused_emg = ^{emg_req, emg_phase};
   assign emg_on     = 1'b0;
   assign emg_ph     = 2'd0;
`endif

   // Round-robin search starting just after the last granted phase.
   logic [1:0] rr_sel;
   logic [1:0] cand;
   logic       found;
   always_comb begin
      rr_sel = 2'd0;
      cand   = 2'd0;
      found  = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cand = last + 2'(i);
         if (!found && req[cand]) begin
            rr_sel = cand;
            found  = 1'b1;
         end
      end
   end

   // Green-phase decision terms.
   logic       other;
   logic       gap_out;
   logic       max_out;
   logic       emg_force;
   logic       emg_hold;
   logic [1:0] grant_sel;
   logic [3:0] act_onehot;
   logic [3:0] grant_onehot;
   always_comb begin
      act_onehot   = 4'b0001 << active_phase;
      other        = |(req & ~act_onehot);
      gap_out      = (tmr >= MIN_LIM) && other && !req[active_phase];
      max_out      = (tmr >= MAX_LIM) && other;
      emg_force    = emg_on && (active_phase != emg_ph);
      emg_hold     = emg_on && (active_phase == emg_ph);
      grant_sel    = emg_on ? emg_ph : rr_sel;
      grant_onehot = 4'b0001 << grant_sel;
   end

   // Sequencer with registered lamp outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_ALLRED;
         tmr            <= '0;
         last           <= 2'd3;
         active_phase   <= 2'd0;
         green          <= 4'h0;
         yellow         <= 4'h0;
         red            <= 4'hF;
         phase_start    <= 1'b0;
         preempt_active <= 1'b0;
      end else begin
         phase_start    <= 1'b0;
         preempt_active <= emg_on;
         case (state)
            ST_ALLRED: begin
               if (tick) begin
                  if (tmr == AR_LIM) begin
                     state        <= ST_GREEN;
                     tmr          <= '0;
                     active_phase <= grant_sel;
                     last         <= grant_sel;
                     phase_start  <= 1'b1;
                     green        <= grant_onehot;
                     red          <= ~grant_onehot;
                  end else begin
                     tmr <= tmr + TMR_ONE;
                  end
               end
            end
            ST_GREEN: begin
               // Preemption toward another phase does not wait for a tick.
               if (emg_force || (tick && !emg_hold && (gap_out || max_out))) begin
                  state  <= ST_YELLOW;
                  tmr    <= '0;
                  green  <= 4'h0;
                  yellow <= act_onehot;
               end else if (tick && (tmr < MAX_LIM)) begin
                  tmr <= tmr + TMR_ONE;
               end
            end
            ST_YELLOW: begin
               if (tick) begin
                  if (tmr == YEL_LIM) begin
                     state  <= ST_ALLRED;
                     tmr    <= '0;
                     yellow <= 4'h0;
                     red    <= 4'hF;
                  end else begin
                     tmr <= tmr + TMR_ONE;
                  end
               end
            end
            default: begin
               state  <= ST_ALLRED;
               tmr    <= '0;
               green  <= 4'h0;
               yellow <= 4'h0;
               red    <= 4'hF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler: a tick-counting
// behavioural model compared every cycle, plus directed literal checks.
module tb_intersection_phase_scheduler;

   localparam int MIN_G = 5;
   localparam int MAX_G = 20;
   localparam int YEL   = 3;
   localparam int AR    = 2;
   localparam int CWID  = 5;
`ifdef EMERGENCY_PREEMPT_EN
   localparam bit EMG_EN = 1'b1;
`else
   localparam bit EMG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       tick = 1'b0;
   logic [3:0] req = 4'h0;
   logic       emg_req = 1'b0;
   logic [1:0] emg_phase = 2'd0;
   logic [3:0] green, yellow, red;
   logic [1:0] active_phase;
   logic       phase_start, preempt_active;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   intersection_phase_scheduler #(
      .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_T(YEL),
      .ALLRED_T(AR), .CW(CWID)
   ) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .req(req),
      .emg_req(emg_req), .emg_phase(emg_phase),
      .green(green), .yellow(yellow), .red(red),
      .active_phase(active_phase), .phase_start(phase_start),
      .preempt_active(preempt_active)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode 0=all-red, 1=green, 2=yellow; counts ticks seen.
   int m_mode = 0;
   int m_elapsed = 0;
   int m_phase = 0;
   int m_last = 3;
   bit m_start = 1'b0;
   bit m_pre = 1'b0;

   function automatic int rr_pick(input int from_last, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(from_last + k) % 4]) return (from_last + k) % 4;
      end
      return 0;
   endfunction

   always @(posedge clk or negedge reset_n) begin : model
      bit emg;
      bit others;
      if (!reset_n) begin
         m_mode = 0; m_elapsed = 0; m_phase = 0; m_last = 3;
         m_start = 1'b0; m_pre = 1'b0;
      end else begin
         emg = EMG_EN && emg_req;
         others = (req & ~(4'b0001 << m_phase)) != 4'h0;
         m_start = 1'b0;
         m_pre = emg;
         if (m_mode == 0) begin
            if (tick) begin
               m_elapsed++;
               if (m_elapsed == AR) begin
                  m_phase = emg ? int'(emg_phase) : rr_pick(m_last, req);
                  m_last = m_phase;
                  m_mode = 1; m_elapsed = 0; m_start = 1'b1;
               end
            end
         end else if (m_mode == 1) begin
            if (emg && m_phase != int'(emg_phase)) begin
               m_mode = 2; m_elapsed = 0;
            end else if (tick) begin
               m_elapsed++;
               if (!emg && others &&
                   ((m_elapsed >= MIN_G && !req[m_phase]) || m_elapsed >= MAX_G)) begin
                  m_mode = 2; m_elapsed = 0;
               end
            end
         end else begin
            if (tick) begin
               m_elapsed++;
               if (m_elapsed == YEL) begin
                  m_mode = 0; m_elapsed = 0;
               end
            end
         end
      end
   end

   task automatic compare_loop();
      logic [3:0] eg, ey, er;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            eg = (m_mode == 1) ? 4'(1 << m_phase) : 4'h0;
            ey = (m_mode == 2) ? 4'(1 << m_phase) : 4'h0;
            er = ~(eg | ey);
            tests++;
            if ({green, yellow, red, active_phase, phase_start, preempt_active} !==
                {eg, ey, er, 2'(m_phase), m_start, m_pre}) begin
               fails++;
               $display("FAIL model_cycle t=%0t got g=%b y=%b r=%b ap=%0d ps=%b pa=%b required g=%b y=%b r=%b ap=%0d ps=%b pa=%b",
                        $time, green, yellow, red, active_phase, phase_start, preempt_active,
                        eg, ey, er, m_phase, m_start, m_pre);
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0t got=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Tick every 4 cycles; returns just after the nth tick has been sampled.
   task automatic ticks(input int n);
      repeat (n) begin
         idle(2);
         @(negedge clk) tick = 1'b1;
         @(negedge clk) tick = 1'b0;
      end
   endtask

   task automatic do_reset(input logic [3:0] r);
      @(negedge clk);
      #2 reset_n = 1'b0;
      tick = 1'b0;
      req = r;
      emg_req = 1'b0;
      #1;
      chk("rst_red", 32'(red), 32'hF);
      chk("rst_green", 32'(green), 32'h0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_start(input int max_ticks, output int ph);
      ph = -1;
      for (int i = 0; i < max_ticks; i++) begin
         ticks(1);
         if (phase_start) begin
            ph = int'(active_phase);
            break;
         end
      end
      if (ph < 0) chk("start_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int ph;
      fork
         compare_loop();
      join_none
      #1 reset_n = 1'b0;
      #10 reset_n = 1'b1;
      @(negedge clk);
      do_reset(4'h0);
      cmp_en = 1'b1;

      // Power-up to home phase 0, then rest in green
      chk("reset_yellow", 32'(yellow), 32'h0);
      chk("reset_ap", 32'(active_phase), 32'd0);
      chk("reset_ps", 32'(phase_start), 32'd0);
      chk("reset_pa", 32'(preempt_active), 32'd0);
      ticks(1);
      chk("ar_tick1_red", 32'(red), 32'hF);
      ticks(1);
      chk("home_green", 32'(green), 32'b0001);
      chk("home_ps", 32'(phase_start), 32'd1);
      chk("home_ap", 32'(active_phase), 32'd0);
      idle(1);
      chk("ps_one_cycle", 32'(phase_start), 32'd0);
      ticks(25);
      chk("rest_green", 32'(green), 32'b0001);

      // Gap-out after minimum green
      do_reset(4'h0);
      ticks(2);
      req = 4'b0100;
      ticks(4);
      chk("gap_still_green", 32'(green), 32'b0001);
      ticks(1);
      chk("gap_yellow", 32'(yellow), 32'b0001);
      chk("gap_green_off", 32'(green), 32'h0);
      ticks(2);
      chk("yel_tick2", 32'(yellow), 32'b0001);
      ticks(1);
      chk("ar_after_yel", 32'(red), 32'hF);
      ticks(1);
      chk("ar_tick1", 32'(red), 32'hF);
      ticks(1);
      chk("gap_next_green", 32'(green), 32'b0100);
      chk("gap_next_ap", 32'(active_phase), 32'd2);

      // Max-out alternation between phases 0 and 2
      do_reset(4'b0101);
      ticks(2);
      chk("max_g0", 32'(green), 32'b0001);
      ticks(19);
      chk("max_g0_hold", 32'(green), 32'b0001);
      ticks(1);
      chk("max_y0", 32'(yellow), 32'b0001);
      ticks(5);
      chk("max_g2", 32'(green), 32'b0100);
      chk("max_ap2", 32'(active_phase), 32'd2);
      ticks(20);
      chk("max_y2", 32'(yellow), 32'b0100);
      ticks(5);
      chk("max_back_g0", 32'(green), 32'b0001);

      // Full round-robin from phase 3 with wrap of the last pointer
      do_reset(4'b1000);
      ticks(2);
      chk("rr_start_ap3", 32'(active_phase), 32'd3);
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_start(40, ph);
         chk("rr_order", 32'(ph), 32'(i));
      end

      // Preemption from phase 1 toward phase 3
      do_reset(4'b0010);
      ticks(2);
      chk("pre_g1", 32'(green), 32'b0010);
      ticks(1);
      req = 4'b0011;
      emg_phase = 2'd3;
      emg_req = 1'b1;
      idle(1);
      if (EMG_EN) begin
         chk("pre_yellow_now", 32'(yellow), 32'b0010);
         chk("pre_active", 32'(preempt_active), 32'd1);
      end else begin
         chk("nopre_green", 32'(green), 32'b0010);
         chk("nopre_active", 32'(preempt_active), 32'd0);
      end
      ticks(3);
      if (EMG_EN) chk("pre_allred", 32'(red), 32'hF);
      ticks(2);
      if (EMG_EN) begin
         chk("pre_g3", 32'(green), 32'b1000);
         chk("pre_ap3", 32'(active_phase), 32'd3);
      end else begin
         chk("nopre_still_g1", 32'(green), 32'b0010);
      end
      emg_req = 1'b0;
      ticks(10);

      // Reset mid-yellow
      do_reset(4'h0);
      ticks(2);
      req = 4'b0100;
      ticks(6);
      chk("midy_yellow", 32'(yellow), 32'b0001);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midy_red", 32'(red), 32'hF);
      chk("midy_yel_off", 32'(yellow), 32'h0);
      req = 4'h0;
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      ticks(1);
      chk("midy_ar", 32'(red), 32'hF);
      ticks(1);
      chk("midy_restart_g0", 32'(green), 32'b0001);
      chk("midy_restart_ps", 32'(phase_start), 32'd1);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
